// File: rtl/match_round_controller.sv
// Round/match sequencer for a two-player fighting game: countdown, timed rounds, KO/timeout
// scoring and end-of-round/match holds. Optional macro MATCH_SUDDEN_DEATH_EN adds sudden death.
module match_round_controller #(
  parameter int TICKS_PER_SEC = 60,
  parameter int HP_W          = 3,
  parameter int GUARD_W       = 3,
  parameter int COUNTDOWN_S   = 3,
  parameter int ROUND_S       = 99,
  parameter int ROUNDS_TO_WIN = 2,
  parameter int END_HOLD_S    = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick_sel,
  input  logic               start,
  input  logic               abort,
  input  logic               p1_hit,
  input  logic               p2_hit,
  input  logic               p1_block,
  input  logic               p2_block,
  output logic [HP_W-1:0]    p1_health,
  output logic [HP_W-1:0]    p2_health,
  output logic [GUARD_W-1:0] p1_guard,
  output logic [GUARD_W-1:0] p2_guard,
  output logic [2:0]         p1_rounds,
  output logic [2:0]         p2_rounds,
  output logic [7:0]         seconds_left,
  output logic [2:0]         phase,
  output logic [1:0]         round_winner,
  output logic               input_active,
  output logic               match_done
);

  localparam logic [2:0] PH_IDLE      = 3'd0;
  localparam logic [2:0] PH_COUNTDOWN = 3'd1;
  localparam logic [2:0] PH_ACTIVE    = 3'd2;
  localparam logic [2:0] PH_ROUND_END = 3'd3;
  localparam logic [2:0] PH_MATCH_END = 3'd4;
  localparam logic [2:0] PH_SUDDEN    = 3'd5;

  localparam int               DIV_W      = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(TICKS_PER_SEC - 1);
  localparam logic [7:0]       HOLD_LAST  = 8'(END_HOLD_S - 1);
  localparam logic [2:0]       WIN_ROUNDS = 3'(ROUNDS_TO_WIN);

  logic [DIV_W-1:0] div_cnt;
  logic [7:0]       hold_cnt;
  logic [2:0]       next_phase;
  logic [1:0]       next_winner;
  logic             tick, hold_done, phase_change, hit_en;
  logic             p1_dmg, p2_dmg, p1_ko, p2_ko;

  assign tick         = tick_sel | (div_cnt == DIV_LAST);
  assign hold_done    = tick && (hold_cnt == HOLD_LAST);
  // A block with an empty guard is a guard break and lands as a hit.
  assign p1_dmg       = p1_hit | (p1_block & (p1_guard == '0));
  assign p2_dmg       = p2_hit | (p2_block & (p2_guard == '0));
  assign p1_ko        = (p1_health == '0);
  assign p2_ko        = (p2_health == '0);
  assign input_active = (phase == PH_ACTIVE) || (phase == PH_SUDDEN);
  assign match_done   = (phase == PH_MATCH_END);
  assign phase_change = (next_phase != phase);
  // In ACTIVE, the cycle that ends the round is scored on registered health, so freeze it.
  assign hit_en       = input_active && ((phase == PH_SUDDEN) || !phase_change);

  // NOTE: every variable assigned here gets a default first so no latch is inferred.
  always_comb begin
    next_phase  = phase;
    next_winner = 2'd0;
    case (phase)
      PH_IDLE:      if (start) next_phase = PH_COUNTDOWN;
      PH_COUNTDOWN: if (tick && seconds_left <= 8'd1) next_phase = PH_ACTIVE;
      PH_ACTIVE: begin
        if (p1_ko || p2_ko) begin
          next_phase  = PH_ROUND_END;
          next_winner = (p1_ko && p2_ko) ? 2'd3 : (p1_ko ? 2'd2 : 2'd1);
        end else if (seconds_left == 8'd0) begin
          next_phase = PH_ROUND_END;
          if (p1_health > p2_health)      next_winner = 2'd1;
          else if (p2_health > p1_health) next_winner = 2'd2;
          else begin
`ifdef MATCH_SUDDEN_DEATH_EN
            next_phase = PH_SUDDEN;
`else
            next_winner = 2'd3;
`endif
          end
        end
      end
      PH_SUDDEN: begin
        if (p1_dmg || p2_dmg) begin
          next_phase  = PH_ROUND_END;
          next_winner = (p1_dmg && p2_dmg) ? 2'd3 : (p1_dmg ? 2'd2 : 2'd1);
        end
      end
      PH_ROUND_END: begin
        if (hold_done)
          next_phase = (p1_rounds == WIN_ROUNDS || p2_rounds == WIN_ROUNDS) ? PH_MATCH_END
                                                                            : PH_COUNTDOWN;
      end
      PH_MATCH_END: if (hold_done) next_phase = PH_IDLE;
      default:      next_phase = PH_IDLE;
    endcase
    if (abort) next_phase = PH_IDLE;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase        <= PH_IDLE;
      div_cnt      <= '0;
      hold_cnt     <= '0;
      seconds_left <= '0;
      round_winner <= 2'd0;
      p1_health    <= '1;
      p2_health    <= '1;
      p1_guard     <= '1;
      p2_guard     <= '1;
      p1_rounds    <= '0;
      p2_rounds    <= '0;
    end else begin
      phase <= next_phase;

      if (phase_change || tick) div_cnt <= '0;
      else                      div_cnt <= div_cnt + DIV_W'(1);

      if (phase_change) hold_cnt <= '0;
      else if (tick && (phase == PH_ROUND_END || phase == PH_MATCH_END))
        hold_cnt <= hold_cnt + 8'd1;

      if (phase_change) begin
        case (next_phase)
          PH_IDLE:      seconds_left <= '0;
          PH_COUNTDOWN: seconds_left <= 8'(COUNTDOWN_S);
          PH_ACTIVE:    seconds_left <= 8'(ROUND_S);
          default:      seconds_left <= seconds_left;
        endcase
      end else if (tick && (phase == PH_COUNTDOWN || phase == PH_ACTIVE) && seconds_left != 8'd0)
        seconds_left <= seconds_left - 8'd1;

      if (next_phase == PH_IDLE || next_phase == PH_COUNTDOWN) round_winner <= 2'd0;
      else if (next_phase == PH_ROUND_END && phase_change) round_winner <= next_winner;

      if (next_phase == PH_IDLE) begin
        p1_rounds <= '0;
        p2_rounds <= '0;
      end else if (next_phase == PH_ROUND_END && phase_change) begin
        if (next_winner == 2'd1 && p1_rounds != 3'd7) p1_rounds <= p1_rounds + 3'd1;
        if (next_winner == 2'd2 && p2_rounds != 3'd7) p2_rounds <= p2_rounds + 3'd1;
      end

      if (next_phase == PH_IDLE || (phase == PH_ROUND_END && next_phase == PH_COUNTDOWN)) begin
        p1_health <= '1;
        p2_health <= '1;
        p1_guard  <= '1;
        p2_guard  <= '1;
      end else if (hit_en) begin
        if (p1_dmg)        p1_health <= p1_health >> 1;
        else if (p1_block) p1_guard  <= p1_guard >> 1;
        if (p2_dmg)        p2_health <= p2_health >> 1;
        else if (p2_block) p2_guard  <= p2_guard >> 1;
      end
    end
  end

endmodule

// File: tb/tb_match_round_controller.sv
// Directed bench for match_round_controller: countdown, hits/blocks, KO/draw/timeout scoring,
// match end, abort and asynchronous reset. Built without MATCH_SUDDEN_DEATH_EN.
module tb_match_round_controller;

  logic       clk = 1'b0;
  logic       rst, tick_sel, start, abort;
  logic       p1_hit, p2_hit, p1_block, p2_block;
  logic [2:0] p1_health, p2_health, p1_guard, p2_guard;
  logic [2:0] p1_rounds, p2_rounds;
  logic [7:0] seconds_left;
  logic [2:0] phase;
  logic [1:0] round_winner;
  logic       input_active, match_done;

  int total  = 0;
  int passed = 0;
  int failed = 0;

  // Four clocks per second so the divider path is observable in a short run.
  match_round_controller #(.TICKS_PER_SEC(4)) dut (
    .clk(clk), .rst(rst), .tick_sel(tick_sel), .start(start), .abort(abort),
    .p1_hit(p1_hit), .p2_hit(p2_hit), .p1_block(p1_block), .p2_block(p2_block),
    .p1_health(p1_health), .p2_health(p2_health), .p1_guard(p1_guard), .p2_guard(p2_guard),
    .p1_rounds(p1_rounds), .p2_rounds(p2_rounds), .seconds_left(seconds_left),
    .phase(phase), .round_winner(round_winner), .input_active(input_active),
    .match_done(match_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic h1, input logic h2, input logic b1, input logic b2);
    p1_hit = h1; p2_hit = h2; p1_block = b1; p2_block = b2;
    step();
    p1_hit = 1'b0; p2_hit = 1'b0; p1_block = 1'b0; p2_block = 1'b0;
  endtask

  task automatic wait_time_zero(input string tag);
    for (int i = 0; i < 120 && seconds_left != 8'd0; i++) step();
    check(tag, seconds_left, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; tick_sel = 1'b1; start = 1'b0; abort = 1'b0;
    p1_hit = 1'b0; p2_hit = 1'b0; p1_block = 1'b0; p2_block = 1'b0;
    #12;
    check("rst_phase", phase, 0);
    check("rst_p1_health", p1_health, 7);
    check("rst_p2_guard", p2_guard, 7);
    check("rst_rounds", {p1_rounds, p2_rounds}, 0);
    check("rst_seconds", seconds_left, 0);
    check("rst_winner", round_winner, 0);
    check("rst_input_active", input_active, 0);
    check("rst_match_done", match_done, 0);
    rst = 1'b0;

    // Countdown 3,2,1 then ACTIVE at 99
    start = 1'b1; step(); start = 1'b0;
    check("cd_phase", phase, 1);
    check("cd_s3", seconds_left, 3);
    step(); check("cd_s2", seconds_left, 2);
    step(); check("cd_s1", seconds_left, 1);
    step();
    check("act_phase", phase, 2);
    check("act_s99", seconds_left, 99);
    check("act_input_active", input_active, 1);

    // Round 1: P2 knocked out by three hits
    pulse(0, 1, 0, 0); check("r1_p2_hp_a", p2_health, 3'b011);
    pulse(0, 1, 0, 0); check("r1_p2_hp_b", p2_health, 3'b001);
    pulse(0, 1, 0, 0); check("r1_p2_hp_c", p2_health, 3'b000);
    check("r1_ko_cycle_phase", phase, 2);
    step();
    check("r1_end_phase", phase, 3);
    check("r1_winner", round_winner, 1);
    check("r1_p1_rounds", p1_rounds, 1);
    check("r1_end_input_active", input_active, 0);
    repeat (4) step();
    check("r1_hold_phase", phase, 3);
    step();
    check("r2_cd_phase", phase, 1);
    check("r2_cd_s3", seconds_left, 3);
    check("r2_p2_restored", p2_health, 7);
    check("r2_winner_clear", round_winner, 0);

    // Hits during COUNTDOWN are ignored
    pulse(1, 0, 0, 0);
    check("cd_hit_ignored", p1_health, 7);
    check("cd_s2_again", seconds_left, 2);
    repeat (2) step();
    check("r2_act_phase", phase, 2);

    // Guard drain and guard break
    pulse(0, 0, 1, 0); check("r2_guard_a", p1_guard, 3'b011);
    pulse(0, 0, 1, 0); check("r2_guard_b", p1_guard, 3'b001);
    pulse(0, 0, 1, 0); check("r2_guard_c", p1_guard, 3'b000);
    check("r2_health_pre_break", p1_health, 7);
    pulse(0, 0, 1, 0); check("r2_guard_break_hp", p1_health, 3'b011);
    check("r2_guard_stays_0", p1_guard, 0);

    // Both at 001, simultaneous hits -> draw
    pulse(1, 0, 0, 0); check("r2_p1_hp_1", p1_health, 3'b001);
    pulse(0, 1, 0, 0);
    pulse(0, 1, 0, 0); check("r2_p2_hp_1", p2_health, 3'b001);
    pulse(1, 1, 0, 0);
    check("r2_both_zero", {p1_health, p2_health}, 0);
    step();
    check("r2_end_phase", phase, 3);
    check("r2_draw", round_winner, 3);
    check("r2_rounds", {p1_rounds, p2_rounds}, {3'd1, 3'd0});
    repeat (5) step();
    check("r3_cd_phase", phase, 1);
    repeat (3) step();
    check("r3_act_phase", phase, 2);

    // Hit overrides same-player block
    pulse(1, 0, 1, 0);
    check("r3_override_hp", p1_health, 3'b011);
    check("r3_override_guard", p1_guard, 7);
    repeat (3) pulse(0, 1, 0, 0);
    check("r3_p2_zero", p2_health, 0);
    step();
    check("r3_winner", round_winner, 1);
    check("r3_p1_rounds", p1_rounds, 2);
    repeat (4) step();
    check("r3_hold_phase", phase, 3);
    step();
    check("me_phase", phase, 4);
    check("me_done_0", match_done, 1);
    start = 1'b1; step(); start = 1'b0;
    check("me_start_ignored", phase, 4);
    repeat (3) step();
    check("me_done_4", match_done, 1);
    step();
    check("me_idle_phase", phase, 0);
    check("me_idle_done", match_done, 0);
    check("me_idle_rounds", p1_rounds, 0);
    check("me_idle_winner", round_winner, 0);

    // Timeout: greater health wins, then equal health draws
    start = 1'b1; step(); start = 1'b0;
    repeat (3) step();
    check("to_act_phase", phase, 2);
    pulse(0, 1, 0, 0);
    wait_time_zero("to1_wait");
    check("to1_still_active", phase, 2);
    step();
    check("to1_phase", phase, 3);
    check("to1_winner", round_winner, 1);
    repeat (5) step();
    repeat (3) step();
    check("to2_act_phase", phase, 2);
    wait_time_zero("to2_wait");
    step();
    check("to2_phase", phase, 3);
    check("to2_draw", round_winner, 3);
    check("to2_rounds", {p1_rounds, p2_rounds}, {3'd1, 3'd0});

    abort = 1'b1; step(); abort = 1'b0;
    check("abort_end_phase", phase, 0);

    // Divider timing with four clocks per second
    tick_sel = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    repeat (3) step();
    check("div_s3_hold", seconds_left, 3);
    step();
    check("div_s2", seconds_left, 2);
    repeat (8) step();
    check("div_act_phase", phase, 2);
    check("div_act_s99", seconds_left, 99);
    repeat (4) step();
    check("div_act_s98", seconds_left, 98);
    abort = 1'b1;
    pulse(1, 0, 0, 0);
    abort = 1'b0;
    check("abort_phase", phase, 0);
    check("abort_hit_dropped", p1_health, 7);
    check("abort_input_active", input_active, 0);

    // Asynchronous reset mid-COUNTDOWN
    start = 1'b1; step(); start = 1'b0;
    step();
    check("pre_rst_phase", phase, 1);
    rst = 1'b1;
    #1;
    check("arst_phase", phase, 0);
    check("arst_seconds", seconds_left, 0);
    check("arst_health", {p1_health, p2_health}, 6'h3f);
    check("arst_winner", round_winner, 0);
    rst = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    repeat (3) step();
    check("post_rst_s3", seconds_left, 3);
    step();
    check("post_rst_s2", seconds_left, 2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/match_round_controller.md
MATCH_ROUND_CONTROLLER -- requirements
Module: match_round_controller

Interface
REQ-001 Parameter TICKS_PER_SEC, default 60: clk cycles per second when tick_sel=0.
REQ-002 Parameter HP_W, default 3: health thermometer width.
REQ-003 Parameter GUARD_W, default 3: block-guard thermometer width.
REQ-004 Parameter COUNTDOWN_S, default 3: pre-round countdown length in seconds.
REQ-005 Parameter ROUND_S, default 99: round time in seconds (max 255).
REQ-006 Parameter ROUNDS_TO_WIN, default 2: round wins that end the match (1..7).
REQ-007 Parameter END_HOLD_S, default 5: seconds held in ROUND_END and in MATCH_END.
REQ-008 clk  in  1  single clock; all logic on rising edge.
REQ-009 rst  in  1  asynchronous, active-high reset.
REQ-010 tick_sel  in  1  0: seconds from the TICKS_PER_SEC divider; 1: every clk is one second (button-clock/debug).
REQ-011 start  in  1  level; starts a match from IDLE.
REQ-012 abort  in  1  level; returns to IDLE from any phase.
REQ-013 p1_hit, p2_hit  in  1 each  one-cycle pulse: that player takes a hit.
REQ-014 p1_block, p2_block  in  1 each  one-cycle pulse: that player blocks a hit.
REQ-015 p1_health, p2_health  out  HP_W each  health thermometer.
REQ-016 p1_guard, p2_guard  out  GUARD_W each  guard thermometer.
REQ-017 p1_rounds, p2_rounds  out  3 each  rounds won.
REQ-018 seconds_left  out  8  countdown or round time remaining.
REQ-019 phase  out  3  IDLE=0, COUNTDOWN=1, ACTIVE=2, ROUND_END=3, MATCH_END=4, SUDDEN=5.
REQ-020 round_winner  out  2  0 none, 1 P1, 2 P2, 3 draw; valid in ROUND_END/MATCH_END.
REQ-021 input_active  out  1  high only in ACTIVE and SUDDEN.
REQ-022 match_done  out  1  high throughout MATCH_END.

Function
REQ-023 Second tick: tick_sel=1 -> tick every cycle; tick_sel=0 -> divider counts 0..TICKS_PER_SEC-1, tick on terminal count; divider clears on every phase entry.
REQ-024 IDLE: health/guard all ones, rounds 0, seconds_left 0, round_winner 0; start=1 -> COUNTDOWN next cycle.
REQ-025 COUNTDOWN: seconds_left loads COUNTDOWN_S on entry, decrements per tick; on tick at value 1 -> ACTIVE with seconds_left=ROUND_S.
REQ-026 ACTIVE: seconds_left decrements per tick, saturating at 0.
REQ-027 Hit: health <= health >> 1 next cycle; hit overrides same-player block in the same cycle.
REQ-028 Block: guard <= guard >> 1; block with guard already 0 is a guard break, applied as a hit.
REQ-029 Simultaneous p1_hit and p2_hit both apply in the same cycle.
REQ-030 Hit/block pulses are ignored outside ACTIVE/SUDDEN.
REQ-031 KO check on registered health: one zero -> other player wins; both zero -> draw; enter ROUND_END the cycle after health reaches 0.
REQ-032 Timeout (seconds_left==0 in ACTIVE): greater health wins; equal -> draw, or SUDDEN (REQ-039).
REQ-033 ROUND_END entry: winner's rounds +1 (saturate at 7); draw increments neither.
REQ-034 ROUND_END holds END_HOLD_S ticks, then MATCH_END if either rounds==ROUNDS_TO_WIN, else health/guard restored and COUNTDOWN.
REQ-035 MATCH_END holds END_HOLD_S ticks, then IDLE; start ignored until IDLE.
REQ-036 abort=1: IDLE next cycle, overriding every other transition and pending hit.

Reset
REQ-037 rst=1 asynchronously forces phase IDLE, health/guard all ones, rounds 0, seconds_left 0, divider 0, round_winner 0, input_active 0, match_done 0; mid-round reset discards the match.

Configuration
REQ-038 Macro MATCH_SUDDEN_DEATH_EN selects timeout-draw handling.
REQ-039 Defined: equal-health timeout -> SUDDEN (seconds_left frozen 0, inputs active); first hit ends round for opponent, simultaneous hits -> draw. Undefined: -> ROUND_END draw; phase 5 never produced.

Verification
REQ-040 tick_sel=1, start pulse -> phase 1 with seconds_left 3,2,1, then phase 2 with seconds_left 99, input_active=1.
REQ-041 Three p2_hit pulses in ACTIVE -> p2_health 011,001,000; ROUND_END, round_winner=1, p1_rounds=1.
REQ-042 Four p1_block pulses -> p1_guard 011,001,000, then guard break: p1_health=011.
REQ-043 Same-cycle p1_hit+p2_hit at health 001 each -> both 000, round_winner=3, rounds unchanged.
REQ-044 Default params, P1 wins two rounds -> MATCH_END, match_done=1 for 5 ticks, then IDLE, p1_rounds cleared.
REQ-045 tick_sel=0, TICKS_PER_SEC=4, abort mid-ACTIVE -> IDLE next cycle; rst mid-COUNTDOWN -> all REQ-037 values immediately.
